// File: rtl/pipe_control_unit.sv
// Control and hazard unit for the 5-stage pipeline: decodes IF/ID, carries control bits
// down to WB, and produces forwarding selects, stall/flush and the decode-stage branch take.
module pipe_control_unit #(
    parameter int unsigned REG_AW = 5,
    parameter int unsigned OP_W   = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       instrD,
    input  logic              equalD,
    output logic              regWrite,
    output logic              mem2Reg,
    output logic              memWrite,
    output logic              regDst,
    output logic              aluSrcB,
    output logic [2:0]        aluControl,
    output logic [1:0]        fad,
    output logic [1:0]        fbd,
    output logic              pcSrc,
    output logic              stall,
    output logic              flush
);

    localparam logic [OP_W-1:0] OpRtype = OP_W'('h00);
    localparam logic [OP_W-1:0] OpLw    = OP_W'('h23);
    localparam logic [OP_W-1:0] OpSw    = OP_W'('h2B);
    localparam logic [OP_W-1:0] OpBeq   = OP_W'('h04);
    localparam logic [OP_W-1:0] OpAddi  = OP_W'('h08);

    localparam logic [OP_W-1:0] FnAdd = OP_W'('h20);
    localparam logic [OP_W-1:0] FnSub = OP_W'('h22);
    localparam logic [OP_W-1:0] FnAnd = OP_W'('h24);
    localparam logic [OP_W-1:0] FnOr  = OP_W'('h25);
    localparam logic [OP_W-1:0] FnSlt = OP_W'('h2A);

    localparam logic [REG_AW-1:0] RegZero = '0;

    logic [OP_W-1:0]   op_d;
    logic [OP_W-1:0]   funct_d;
    logic [REG_AW-1:0] rs_d, rt_d, rd_d;
    logic              unused_shamt;

    assign op_d         = instrD[31 -: OP_W];
    assign funct_d      = instrD[OP_W-1:0];
    assign rs_d         = instrD[25 -: REG_AW];
    assign rt_d         = instrD[20 -: REG_AW];
    assign rd_d         = instrD[15 -: REG_AW];
    assign unused_shamt = ^instrD[10:6];

    logic       dec_reg_write, dec_mem2reg, dec_mem_write, dec_reg_dst, dec_alu_src_b, dec_branch;
    logic [2:0] dec_alu_ctrl;

    always_comb begin
        dec_reg_write = 1'b0;
        dec_mem2reg   = 1'b0;
        dec_mem_write = 1'b0;
        dec_reg_dst   = 1'b0;
        dec_alu_src_b = 1'b0;
        dec_branch    = 1'b0;
        dec_alu_ctrl  = 3'b000;
        case (op_d)
            OpRtype: begin
                dec_reg_write = 1'b1;
                dec_reg_dst   = 1'b1;
                case (funct_d)
                    FnAdd:   dec_alu_ctrl = 3'b010;
                    FnSub:   dec_alu_ctrl = 3'b110;
                    FnAnd:   dec_alu_ctrl = 3'b000;
                    FnOr:    dec_alu_ctrl = 3'b001;
                    FnSlt:   dec_alu_ctrl = 3'b111;
                    default: begin
                        // Unknown funct decodes as a nop.
                        dec_reg_write = 1'b0;
                        dec_reg_dst   = 1'b0;
                    end
                endcase
            end
            OpLw: begin
                dec_reg_write = 1'b1;
                dec_alu_src_b = 1'b1;
                dec_mem2reg   = 1'b1;
                dec_alu_ctrl  = 3'b010;
            end
            OpSw: begin
                dec_mem_write = 1'b1;
                dec_alu_src_b = 1'b1;
                dec_alu_ctrl  = 3'b010;
            end
            OpBeq: begin
                dec_branch   = 1'b1;
                dec_alu_ctrl = 3'b110;
            end
            OpAddi: begin
                dec_reg_write = 1'b1;
                dec_alu_src_b = 1'b1;
                dec_alu_ctrl  = 3'b010;
            end
            default: ;
        endcase
    end

    // ID/EX
    logic              e_reg_write_q, e_mem2reg_q, e_mem_write_q, e_reg_dst_q, e_alu_src_b_q;
    logic              e_reg_write_d, e_mem2reg_d, e_mem_write_d, e_reg_dst_d, e_alu_src_b_d;
    logic [2:0]        e_alu_ctrl_q, e_alu_ctrl_d;
    logic [REG_AW-1:0] e_rs_q, e_rt_q, e_rd_q, e_rs_d, e_rt_d, e_rd_d;
    // EX/MEM
    logic              m_reg_write_q, m_mem2reg_q, m_mem_write_q;
    logic              m_reg_write_d, m_mem2reg_d, m_mem_write_d;
    logic [REG_AW-1:0] m_write_reg_q, m_write_reg_d;
    // MEM/WB
    logic              w_reg_write_q, w_mem2reg_q, w_reg_write_d, w_mem2reg_d;
    logic [REG_AW-1:0] w_write_reg_q, w_write_reg_d;

    logic [REG_AW-1:0] write_reg_e;
    assign write_reg_e = e_reg_dst_q ? e_rd_q : e_rt_q;

    logic lw_stall, br_stall, hazard;

    always_comb begin
        lw_stall = e_mem2reg_q && (e_rt_q != RegZero) && ((e_rt_q == rs_d) || (e_rt_q == rt_d));
        br_stall = dec_branch &&
                   ((e_reg_write_q && (write_reg_e != RegZero) &&
                     ((write_reg_e == rs_d) || (write_reg_e == rt_d))) ||
                    (m_mem2reg_q && (m_write_reg_q != RegZero) &&
                     ((m_write_reg_q == rs_d) || (m_write_reg_q == rt_d))));
        hazard   = !rst && (lw_stall || br_stall);
    end

    assign stall = hazard;
    assign flush = hazard;
    assign pcSrc = !rst && dec_branch && equalD && !hazard;

    always_comb begin
        e_reg_write_d = dec_reg_write;
        e_mem2reg_d   = dec_mem2reg;
        e_mem_write_d = dec_mem_write;
        e_reg_dst_d   = dec_reg_dst;
        e_alu_src_b_d = dec_alu_src_b;
        e_alu_ctrl_d  = dec_alu_ctrl;
        e_rs_d        = rs_d;
        e_rt_d        = rt_d;
        e_rd_d        = rd_d;
        if (hazard) begin
            e_reg_write_d = 1'b0;
            e_mem2reg_d   = 1'b0;
            e_mem_write_d = 1'b0;
            e_reg_dst_d   = 1'b0;
            e_alu_src_b_d = 1'b0;
            e_alu_ctrl_d  = 3'b000;
            e_rs_d        = '0;
            e_rt_d        = '0;
            e_rd_d        = '0;
        end
        m_reg_write_d = e_reg_write_q;
        m_mem2reg_d   = e_mem2reg_q;
        m_mem_write_d = e_mem_write_q;
        m_write_reg_d = write_reg_e;
        w_reg_write_d = m_reg_write_q;
        w_mem2reg_d   = m_mem2reg_q;
        w_write_reg_d = m_write_reg_q;
        if (rst) begin
            e_reg_write_d = 1'b0;
            e_mem2reg_d   = 1'b0;
            e_mem_write_d = 1'b0;
            e_reg_dst_d   = 1'b0;
            e_alu_src_b_d = 1'b0;
            e_alu_ctrl_d  = 3'b000;
            e_rs_d        = '0;
            e_rt_d        = '0;
            e_rd_d        = '0;
            m_reg_write_d = 1'b0;
            m_mem2reg_d   = 1'b0;
            m_mem_write_d = 1'b0;
            m_write_reg_d = '0;
            w_reg_write_d = 1'b0;
            w_mem2reg_d   = 1'b0;
            w_write_reg_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        e_reg_write_q <= e_reg_write_d;
        e_mem2reg_q   <= e_mem2reg_d;
        e_mem_write_q <= e_mem_write_d;
        e_reg_dst_q   <= e_reg_dst_d;
        e_alu_src_b_q <= e_alu_src_b_d;
        e_alu_ctrl_q  <= e_alu_ctrl_d;
        e_rs_q        <= e_rs_d;
        e_rt_q        <= e_rt_d;
        e_rd_q        <= e_rd_d;
        m_reg_write_q <= m_reg_write_d;
        m_mem2reg_q   <= m_mem2reg_d;
        m_mem_write_q <= m_mem_write_d;
        m_write_reg_q <= m_write_reg_d;
        w_reg_write_q <= w_reg_write_d;
        w_mem2reg_q   <= w_mem2reg_d;
        w_write_reg_q <= w_write_reg_d;
    end

    // MEM result outranks WB result when both match.
    function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] src,
                                           input logic m_wr, input logic [REG_AW-1:0] m_reg,
                                           input logic w_wr, input logic [REG_AW-1:0] w_reg);
        if (src != RegZero && m_wr && src == m_reg) begin
            return 2'b10;
        end else if (src != RegZero && w_wr && src == w_reg) begin
            return 2'b01;
        end
        return 2'b00;
    endfunction

    assign fad = fwd_sel(e_rs_q, m_reg_write_q, m_write_reg_q, w_reg_write_q, w_write_reg_q);
    assign fbd = fwd_sel(e_rt_q, m_reg_write_q, m_write_reg_q, w_reg_write_q, w_write_reg_q);

    assign regDst     = e_reg_dst_q;
    assign aluSrcB    = e_alu_src_b_q;
    assign aluControl = e_alu_ctrl_q;
    assign memWrite   = m_mem_write_q;
    assign regWrite   = w_reg_write_q;
    assign mem2Reg    = w_mem2reg_q;

endmodule

// File: doc/pipe_control_unit.md
Name: pipe_control_unit

Overview:
Control and hazard stage feeding `dataPath` in the 32-bit 5-stage pipelined processor.
- Decodes the instruction held in the IF/ID register.
- Carries its control bits through internal ID/EX, EX/MEM and MEM/WB control registers, so each stage's signal reaches the datapath in the cycle that stage needs it.
- Generates the forwarding selects (fad/fbd), load-use and branch stalls, flush, and pcSrc.

Parameters:
- REG_AW, 5, register-address width
- OP_W, 6, opcode/funct field width

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- instrD  input  32  instruction in decode stage (from datapath IF/ID register)
- equalD  input  1  register-operand equality from datapath decode comparator
- regWrite  output  1  WB-stage register-file write enable
- mem2Reg  output  1  WB-stage result select (1 = memory data)
- memWrite  output  1  MEM-stage data-memory write enable
- regDst  output  1  EX-stage destination select (1 = rd, 0 = rt)
- aluSrcB  output  1  EX-stage ALU B select (1 = sign-extended immediate)
- aluControl  output  3  EX-stage ALU operation
- fad  output  2  EX forwarding select for A: 00 = register file, 01 = WB result, 10 = MEM ALU result
- fbd  output  2  EX forwarding select for B, same encoding as fad
- pcSrc  output  1  decode-stage taken branch
- stall  output  1  hold PC and IF/ID
- flush  output  1  clear the datapath ID/EX register

Behaviour:
Decode (combinational on instrD):
- opcode = [31:26], rs = [25:21], rt = [20:16], rd = [15:11], funct = [5:0].
- R-type, opcode 0x00: regWrite=1, regDst=1. funct selects aluControl:
  - 0x20 add → 010
  - 0x22 sub → 110
  - 0x24 and → 000
  - 0x25 or → 001
  - 0x2A slt → 111
  - any other funct: all controls 0 (nop).
- lw, 0x23: regWrite=1, aluSrcB=1, mem2Reg=1, aluControl=010.
- sw, 0x2B: memWrite=1, aluSrcB=1, aluControl=010.
- beq, 0x04: branchD=1, aluControl=110.
- addi, 0x08: regWrite=1, aluSrcB=1, aluControl=010.
- Any other opcode: all controls 0.

Control register stages:
- ID/EX stores {regWrite, mem2Reg, memWrite, regDst, aluSrcB, aluControl, rs, rt, rd}.
- EX stage computes writeRegE = regDstE ? rdE : rtE.
- EX/MEM stores {regWrite, mem2Reg, memWrite, writeReg}.
- MEM/WB stores {regWrite, mem2Reg, writeReg}.
- Latency from decode:
  - regDst, aluSrcB, aluControl: 1 cycle after decode.
  - memWrite: 2 cycles after decode.
  - regWrite, mem2Reg: 3 cycles after decode.

Forwarding (combinational from register state):
- fad = 10 if rsE≠0 && regWriteM && rsE==writeRegM.
- Else fad = 01 if rsE≠0 && regWriteW && rsE==writeRegW.
- Else fad = 00.
- MEM forwarding takes priority over WB forwarding.
- fbd: identical rule using rtE.

Hazards:
- lwstall = mem2RegE && rtE≠0 && (rtE==rsD || rtE==rtD).
- brstall = branchD && ((regWriteE && writeRegE≠0 && writeRegE∈{rsD, rtD}) || (mem2RegM && writeRegM≠0 && writeRegM∈{rsD, rtD})).
- stall = flush = lwstall | brstall.
- pcSrc = branchD && equalD && !stall.

Clocked behaviour:
- On a clock edge with flush=1, ID/EX loads all zeros (bubble). EX/MEM and MEM/WB advance normally.
- The stall hold itself is applied by the datapath. This unit just re-decodes instrD, which stays unchanged.

Reset:
- When rst=1 at a clock edge, all three control register stages clear to 0.
- After reset, every registered output is 0: regWrite, mem2Reg, memWrite, regDst, aluSrcB, aluControl=000, fad=00, fbd=00.
- While rst=1, stall, flush and pcSrc are forced to 0.
- Reset asserted mid-operation discards every in-flight instruction; none produces a later write.

Simultaneous events:
- rst has priority over flush.
- A register matching both MEM and WB forwards from MEM (10).
- A branch with equalD=1 that must stall gives pcSrc=0 until the stall clears.

Test Plan:
- Reset: assert rst for 2 cycles with instrD = add $3,$1,$2 → every output 0 during reset and on the first cycle after; regWrite rises exactly 3 cycles after rst release.
- Pipeline latency: issue add $3,$1,$2 (0x00221820) then nops → cycle+1: regDst=1, aluControl=010; cycle+3: regWrite=1, mem2Reg=0.
- Forwarding: add $3,$1,$2 then sub $4,$3,$3 then or $5,$3,$1 → sub in EX sees fad=10, fbd=10; or in EX sees fad=01, fbd=00.
- Load-use: lw $2,0($0) then add $4,$2,$1 → stall=flush=1 for exactly 1 cycle; after the bubble the add in EX sees fad=01.
- Branch: beq $1,$1 with no hazard and equalD=1 → pcSrc=1 in the same cycle. beq $3,$0 directly after add $3 → stall for 1 cycle, pcSrc=0, then pcSrc=1.
- $0 writes: add $0,$1,$2 followed by use of $0 → fad=fbd=00, stall=0.
